// File: rtl/jelly3_axi4l_register_slave.sv
// AXI4-Lite slave exposing NUM_REGS word-wide registers as a flat bus with per-register write pulses.
// Define JELLY3_AXI4L_REGISTER_SLVERR_EN to answer out-of-range accesses with SLVERR.
module jelly3_axi4l_register_slave #(
    parameter int                    ADDR_BITS  = 32,
    parameter int                    DATA_BITS  = 32,
    parameter int                    BYTE_BITS  = 8,
    parameter int                    STRB_BITS  = DATA_BITS / BYTE_BITS,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_BITS-1:0]  INIT_VALUE = '0
) (
    input  logic                           reset,
    input  logic                           clk,

    input  logic [ADDR_BITS-1:0]           s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_BITS-1:0]           s_wdata,
    input  logic [STRB_BITS-1:0]           s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_BITS-1:0]           s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_BITS-1:0]           s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,

    output logic [NUM_REGS*DATA_BITS-1:0]  reg_data,
    output logic [NUM_REGS-1:0]            reg_wen
);

    localparam int IDX_LSB  = $clog2(STRB_BITS);
    localparam int IDX_BITS = ADDR_BITS - IDX_LSB;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef JELLY3_AXI4L_REGISTER_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    logic [DATA_BITS-1:0]  regs [NUM_REGS];

    logic                  aw_held;
    logic [ADDR_BITS-1:0]  awaddr_q;
    logic                  w_held;
    logic [DATA_BITS-1:0]  wdata_q;
    logic [STRB_BITS-1:0]  wstrb_q;

    logic [IDX_BITS-1:0]   aw_idx;
    logic [IDX_BITS-1:0]   ar_idx;
    logic                  aw_in;
    logic                  ar_in;
    logic                  commit;
    logic [DATA_BITS-1:0]  rd_val;

    assign s_awready = !aw_held;
    assign s_wready  = !w_held;
    assign s_arready = !s_rvalid;

    assign aw_idx = awaddr_q[ADDR_BITS-1:IDX_LSB];
    assign ar_idx = s_araddr[ADDR_BITS-1:IDX_LSB];
    assign aw_in  = aw_idx < IDX_BITS'(NUM_REGS);
    assign ar_in  = ar_idx < IDX_BITS'(NUM_REGS);

    // A pending response that is not being accepted blocks the next commit.
    assign commit = aw_held && w_held && (!s_bvalid || s_bready);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_BITS'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // Address/data capture, commit and write response.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            reg_wen  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= INIT_VALUE;
            end
        end else begin
            reg_wen <= '0;

            if (s_awvalid && s_awready) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held  <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end

            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= aw_in ? RESP_OKAY : RESP_OOR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_in && aw_idx == IDX_BITS'(i)) begin
                        reg_wen[i] <= 1'b1;
                        for (int b = 0; b < STRB_BITS; b++) begin
                            if (wstrb_q[b]) begin
                                regs[i][b*BYTE_BITS +: BYTE_BITS] <= wdata_q[b*BYTE_BITS +: BYTE_BITS];
                            end
                        end
                    end
                end
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // Read samples the pre-commit register value on the AR edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (s_arvalid && s_arready) begin
            s_rvalid <= 1'b1;
            s_rdata  <= ar_in ? rd_val : '0;
            s_rresp  <= ar_in ? RESP_OKAY : RESP_OOR;
        end else if (s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_data[i*DATA_BITS +: DATA_BITS] = regs[i];
    end

endmodule

// File: tb/tb_jelly3_axi4l_register_slave.sv
// Scoreboard bench for jelly3_axi4l_register_slave (NUM_REGS=4, 32-bit).
module tb_jelly3_axi4l_register_slave;

    localparam int NR = 4;
`ifdef JELLY3_AXI4L_REGISTER_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          reset = 1'b1;
    logic          clk = 1'b0;
    logic [31:0]   s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [31:0]   s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b1;
    logic [31:0]   s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b1;
    logic [NR*32-1:0] reg_data;
    logic [NR-1:0]    reg_wen;

    jelly3_axi4l_register_slave #(
        .ADDR_BITS(32), .DATA_BITS(32), .BYTE_BITS(8), .STRB_BITS(4),
        .NUM_REGS(NR), .INIT_VALUE('0)
    ) dut (
        .reset(reset), .clk(clk),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_data(reg_data), .reg_wen(reg_wen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]    bq[$];
    logic [33:0]   rq[$];
    logic [NR-1:0] wq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake wait expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] rg(input int i);
        return reg_data[i*32 +: 32];
    endfunction

    // Monitors: inputs change just after posedge, so a negedge view equals the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else chk("bresp", {126'b0, s_bresp}, {126'b0, bq.pop_front()});
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) fail("r_unexpected");
                else chk("rresp_rdata", {94'b0, s_rresp, s_rdata}, {94'b0, rq.pop_front()});
            end
            if (reg_wen != '0) begin
                if (wq.size() == 0) chk("reg_wen_unexpected", {124'b0, reg_wen}, 128'b0);
                else chk("reg_wen", {124'b0, reg_wen}, {124'b0, wq.pop_front()});
            end
        end
    end

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        s_awaddr = a; s_awvalid = 1'b1;
        @(negedge clk);
        while (!s_awready && n < 50) begin n++; @(negedge clk); end
        if (!s_awready) fail("aw_wait");
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        @(negedge clk);
        while (!s_wready && n < 50) begin n++; @(negedge clk); end
        if (!s_wready) fail("w_wait");
        @(posedge clk); #1;
        s_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, output int waits);
        int n = 0;
        s_araddr = a; s_arvalid = 1'b1;
        @(negedge clk);
        while (!s_arready && n < 50) begin n++; @(negedge clk); end
        if (!s_arready) fail("ar_wait");
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        waits = n;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            do_aw(a);
            do_w(d, s);
        join
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        cycles(3);
        reset = 1'b0;

        // reset state
        chk("rst_awready", {127'b0, s_awready}, 128'd1);
        chk("rst_wready",  {127'b0, s_wready},  128'd1);
        chk("rst_arready", {127'b0, s_arready}, 128'd1);
        chk("rst_bvalid",  {127'b0, s_bvalid},  128'd0);
        chk("rst_rvalid",  {127'b0, s_rvalid},  128'd0);
        chk("rst_regs",    reg_data,            128'd0);

        // 1: AW and W together, latency and readback
        bq.push_back(2'b00); wq.push_back(4'b0100);
        do_write(32'h08, 32'h12345678, 4'hF);
        chk("t1_bvalid_early", {127'b0, s_bvalid}, 128'd0);
        cycles(1);
        chk("t1_bvalid", {127'b0, s_bvalid}, 128'd1);
        chk("t1_reg2", {96'b0, rg(2)}, {96'b0, 32'h12345678});
        rq.push_back({2'b00, 32'h12345678});
        do_ar(32'h08, w);
        cycles(2);

        // 2: W first, AW three cycles later
        bq.push_back(2'b00); wq.push_back(4'b0010);
        do_w(32'hAABBCCDD, 4'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wready_low", {127'b0, s_wready}, 128'd0);
        end
        @(posedge clk); #1;
        do_aw(32'h04);
        cycles(2);
        chk("t2_reg1", {96'b0, rg(1)}, {96'b0, 32'h00BB00DD});

        // 3: two writes queued behind a stalled response
        s_bready = 1'b0;
        bq.push_back(2'b00); wq.push_back(4'b0001);
        do_write(32'h00, 32'h11111111, 4'hF);
        bq.push_back(2'b00); wq.push_back(4'b1000);
        do_write(32'h0C, 32'h22222222, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_awready_low", {127'b0, s_awready}, 128'd0);
            chk("t3_wready_low",  {127'b0, s_wready},  128'd0);
            chk("t3_bvalid_hold", {127'b0, s_bvalid},  128'd1);
            chk("t3_reg3_wait",   {96'b0, rg(3)},      128'd0);
        end
        @(posedge clk); #1;
        s_bready = 1'b1;
        cycles(3);
        chk("t3_reg0", {96'b0, rg(0)}, {96'b0, 32'h11111111});
        chk("t3_reg3", {96'b0, rg(3)}, {96'b0, 32'h22222222});

        // 4: read held by rready=0, second read follows the handshake
        s_rready = 1'b0;
        rq.push_back({2'b00, 32'h22222222});
        do_ar(32'h0C, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_rvalid",  {127'b0, s_rvalid},  128'd1);
            chk("t4_rdata",   {96'b0, s_rdata},    {96'b0, 32'h22222222});
            chk("t4_arready", {127'b0, s_arready}, 128'd0);
        end
        @(posedge clk); #1;
        s_rready = 1'b1;
        rq.push_back({2'b00, 32'h11111111});
        do_ar(32'h00, w);
        chk("t4_ar2_waits", 128'(w), 128'd1);
        cycles(2);

        // 5: out-of-range write/read, and a zero-strobe write
        bq.push_back(OOR);
        do_write(32'h40, 32'hFFFFFFFF, 4'hF);
        rq.push_back({OOR, 32'h0});
        do_ar(32'h40, w);
        bq.push_back(2'b00); wq.push_back(4'b0001);
        do_write(32'h00, 32'hDEADBEEF, 4'h0);
        cycles(3);
        chk("t5_regs", reg_data, {32'h22222222, 32'h12345678, 32'h00BB00DD, 32'h11111111});

        // 6: reset with an address held and a read pending
        do_aw(32'h04);
        s_rready = 1'b0;
        do_ar(32'h08, w);
        @(negedge clk);
        chk("t6_aw_held", {127'b0, s_awready}, 128'd0);
        chk("t6_rvalid",  {127'b0, s_rvalid},  128'd1);
        @(posedge clk); #1;
        rq.delete();
        reset = 1'b1;
        cycles(1);
        chk("t6_awready", {127'b0, s_awready}, 128'd1);
        chk("t6_rvalid0", {127'b0, s_rvalid},  128'd0);
        chk("t6_regs",    reg_data,            128'd0);
        reset = 1'b0;
        s_rready = 1'b1;
        s_wdata = 32'h0; s_wstrb = 4'h0;
        cycles(2);
        chk("t6_no_wen", {124'b0, reg_wen}, 128'd0);

        bq.push_back(2'b00); wq.push_back(4'b0100);
        do_write(32'h08, 32'hCAFEF00D, 4'hF);
        cycles(1);
        rq.push_back({2'b00, 32'hCAFEF00D});
        do_ar(32'h08, w);
        cycles(6);

        chk("bq_drained", 128'(bq.size()), 128'd0);
        chk("rq_drained", 128'(rq.size()), 128'd0);
        chk("wq_drained", 128'(wq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
